// File: rtl/aes256_pkg.sv
// Shared constants for the AES-256 stream controller: widths, modes, error bits and
// controller state encoding.
package aes256_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_KEY_W = 256;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_KEY     = 1;
    localparam int unsigned ERR_W       = 2;

    typedef logic [1:0] ctrl_state_t;

    localparam ctrl_state_t StIdle  = 2'd0;
    localparam ctrl_state_t StIssue = 2'd1;
    localparam ctrl_state_t StWait  = 2'd2;
    localparam ctrl_state_t StHold  = 2'd3;

endpackage

// File: rtl/aes256_stream_ctrl.sv
// Host-side controller for the AES-256 core: accepts one block, starts the core, waits for
// done with a timeout and returns the result over a back-pressured stream.
module aes256_stream_ctrl
    import aes256_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 key_load_i,
    input  logic [AES_KEY_W-1:0] key_i,

    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [AES_BLK_W-1:0] s_data_i,
    input  logic                 s_mode_i,

    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [AES_BLK_W-1:0] m_data_o,
    output logic                 m_mode_o,

    output logic                 core_start_o,
    output logic                 core_mode_o,
    output logic [AES_BLK_W-1:0] core_data_o,
    output logic [AES_KEY_W-1:0] core_key_o,
    input  logic [AES_BLK_W-1:0] core_data_i,
    input  logic                 core_valid_i,
    input  logic                 core_busy_i,

    output logic [ERR_W-1:0]     err_o,
    input  logic                 err_clr_i,
    output logic [CNT_W-1:0]     blk_cnt_o
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    ctrl_state_t            state_q,  state_d;
    logic [AES_KEY_W-1:0]   key_q,    key_d;
    logic [AES_BLK_W-1:0]   data_q,   data_d;
    logic                   mode_q,   mode_d;
    logic [AES_BLK_W-1:0]   m_data_q, m_data_d;
    logic                   m_mode_q, m_mode_d;
    logic                   m_valid_q, m_valid_d;
    logic [ERR_W-1:0]       err_q,    err_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [TmoW-1:0]        tmo_q,    tmo_d;
    logic                   start;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        data_d    = data_q;
        mode_d    = mode_q;
        m_data_d  = m_data_q;
        m_mode_d  = m_mode_q;
        m_valid_d = m_valid_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        start     = 1'b0;
        // Clear first so a same-cycle error event still lands.
        err_d     = err_clr_i ? '0 : err_q;

        if (key_load_i) begin
            if (state_q == StIdle) begin
                key_d = key_i;
            end else begin
                err_d[ERR_KEY] = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (s_valid_i) begin
                    data_d  = s_data_i;
                    mode_d  = s_mode_i;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!core_busy_i) begin
                    start   = 1'b1;
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                tmo_d = tmo_q + TmoW'(1);
                // A done pulse on the last allowed cycle still counts as success.
                if (core_valid_i) begin
                    m_data_d  = core_data_i;
                    m_mode_d  = mode_q;
                    m_valid_d = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = StHold;
                end else if (tmo_q == TmoLast) begin
                    err_d[ERR_TIMEOUT] = 1'b1;
                    state_d            = StIdle;
                end
            end
            StHold: begin
                if (m_ready_i) begin
                    m_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            key_q     <= '0;
            data_q    <= '0;
            mode_q    <= MODE_ENC;
            m_data_q  <= '0;
            m_mode_q  <= MODE_ENC;
            m_valid_q <= 1'b0;
            err_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            m_data_q  <= m_data_d;
            m_mode_q  <= m_mode_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign s_ready_o    = (state_q == StIdle);
    assign core_start_o = start;
    assign core_mode_o  = mode_q;
    assign core_data_o  = data_q;
    assign core_key_o   = key_q;
    assign m_valid_o    = m_valid_q;
    assign m_data_o     = m_data_q;
    assign m_mode_o     = m_mode_q;
    assign err_o        = err_q;
    assign blk_cnt_o    = cnt_q;

endmodule

// File: tb/tb_aes256_stream_ctrl.sv
// Self-checking bench for aes256_stream_ctrl: stand-in AES core, transaction-level reference
// model checked every cycle, directed scenarios and randomized traffic.
module tb_aes256_stream_ctrl;
    import aes256_pkg::*;

    localparam int unsigned TMO = 64;
    localparam int unsigned CW  = 32;
    localparam int          LAT = 18;

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load_i;
    logic [255:0] key_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [127:0] s_data_i;
    logic         s_mode_i;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [127:0] m_data_o;
    logic         m_mode_o;
    logic         core_start_o;
    logic         core_mode_o;
    logic [127:0] core_data_o;
    logic [255:0] core_key_o;
    logic [127:0] core_data_i;
    logic         core_valid_i;
    logic         core_busy_i;
    logic [1:0]   err_o;
    logic         err_clr_i;
    logic [CW-1:0] blk_cnt_o;

    aes256_stream_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_load_i   (key_load_i),
        .key_i        (key_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .s_mode_i     (s_mode_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .m_mode_o     (m_mode_o),
        .core_start_o (core_start_o),
        .core_mode_o  (core_mode_o),
        .core_data_o  (core_data_o),
        .core_key_o   (core_key_o),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .core_busy_i  (core_busy_i),
        .err_o        (err_o),
        .err_clr_i    (err_clr_i),
        .blk_cnt_o    (blk_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Stand-in core transform: FIPS-197 C.3 for the known vector, a keyed XOR otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic m,
                                             input logic [255:0] k);
        if (k == FIPS_KEY && m == MODE_ENC && d == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && m == MODE_DEC && d == FIPS_CT) return FIPS_PT;
        return d ^ k[127:0] ^ k[255:128] ^ {128{m}};
    endfunction

    // Core model: answers LAT cycles after the start pulse unless muted.
    logic         core_mute    = 1'b0;
    logic         inject_valid = 1'b0;
    int           start_cnt    = 0;
    int           core_left    = 0;
    bit           core_pend    = 1'b0;
    logic [127:0] core_res     = '0;

    initial begin
        core_valid_i = 1'b0;
        core_data_i  = '0;
        forever begin
            @(negedge clk);
            core_valid_i = inject_valid;
            if (core_pend) begin
                if (core_left == 0) begin
                    core_pend = 1'b0;
                    if (!core_mute) begin
                        core_valid_i = 1'b1;
                        core_data_i  = core_res;
                    end
                end else begin
                    core_left--;
                end
            end
            if (core_start_o === 1'b1) begin
                start_cnt++;
                core_pend = 1'b1;
                core_left = LAT - 1;
                core_res  = core_fn(core_data_o, core_mode_o, core_key_o);
            end
        end
    end

    // Reference model: ph 0 idle / 1 waiting to start / 2 core running / 3 result held.
    int           ph      = 0;
    int           mwaited = 0;
    logic [255:0] mk      = '0;
    logic [127:0] mblk    = '0;
    logic         mmode   = 1'b0;
    logic [127:0] mout    = '0;
    logic         moutm   = 1'b0;
    logic [1:0]   merr    = '0;
    logic [CW-1:0] mcnt   = '0;

    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                ph = 0; mk = '0; mblk = '0; mmode = 1'b0; mout = '0; moutm = 1'b0;
                merr = '0; mcnt = '0; mwaited = 0;
            end else begin
                e = err_clr_i ? 2'b00 : merr;
                if (key_load_i) begin
                    if (ph == 0) mk = key_i;
                    else e[ERR_KEY] = 1'b1;
                end
                case (ph)
                    0: if (s_valid_i) begin mblk = s_data_i; mmode = s_mode_i; ph = 1; end
                    1: if (!core_busy_i) begin ph = 2; mwaited = 0; end
                    2: begin
                        mwaited++;
                        if (core_valid_i) begin
                            mout  = core_fn(mblk, mmode, mk);
                            moutm = mmode;
                            mcnt  = mcnt + 1'b1;
                            ph    = 3;
                        end else if (mwaited == TMO) begin
                            e[ERR_TIMEOUT] = 1'b1;
                            ph = 0;
                        end
                    end
                    default: if (m_ready_i) ph = 0;
                endcase
                merr = e;
            end
        end
    end

    bit chk_en = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("s_ready",    256'(s_ready_o),    256'(ph == 0));
                chk("m_valid",    256'(m_valid_o),    256'(ph == 3));
                chk("core_start", 256'(core_start_o), 256'(ph == 1 && !core_busy_i));
                chk("core_key",   core_key_o,         mk);
                chk("core_data",  256'(core_data_o),  256'(mblk));
                chk("core_mode",  256'(core_mode_o),  256'(mmode));
                chk("m_data",     256'(m_data_o),     256'(mout));
                chk("m_mode",     256'(m_mode_o),     256'(moutm));
                chk("err",        256'(err_o),        256'(merr));
                chk("blk_cnt",    256'(blk_cnt_o),    256'(mcnt));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [127:0] d, input logic m);
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_mode_i  = m;
        step();
        s_valid_i = 1'b0;
    endtask

    task automatic wait_ph(input string name, input int target, output int n);
        n = 0;
        while (ph != target && n < 200) begin
            step();
            n++;
        end
        if (ph != target) begin
            errors++;
            $display("FAIL %s: model state %0d not reached within 200 cycles", name, target);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        rst_n = 1'b0; key_load_i = 1'b0; key_i = '0; s_valid_i = 1'b0; s_data_i = '0;
        s_mode_i = 1'b0; m_ready_i = 1'b0; core_busy_i = 1'b0; err_clr_i = 1'b0;
        step(2);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        chk("rst_s_ready", 256'(s_ready_o), 256'(1));
        chk("rst_m_valid", 256'(m_valid_o), 256'(0));
        chk("rst_blk_cnt", 256'(blk_cnt_o), 256'(0));
        chk("rst_key",     core_key_o,      256'(0));

        // FIPS-197 C.3 encrypt
        key_load_i = 1'b1; key_i = FIPS_KEY;
        step();
        key_load_i = 1'b0;
        send(FIPS_PT, MODE_ENC);
        wait_ph("enc_wait", 3, n);
        chk("enc_latency", 256'(n), 256'(LAT + 1));
        chk("enc_data",    256'(m_data_o), 256'(FIPS_CT));
        chk("enc_mode",    256'(m_mode_o), 256'(MODE_ENC));
        chk("enc_cnt",     256'(blk_cnt_o), 256'(1));
        chk("enc_starts",  256'(start_cnt), 256'(1));
        m_ready_i = 1'b1; step(); m_ready_i = 1'b0;

        // Decrypt, then hold off the result
        send(FIPS_CT, MODE_DEC);
        wait_ph("dec_wait", 3, n);
        chk("dec_data", 256'(m_data_o), 256'(FIPS_PT));
        chk("dec_mode", 256'(m_mode_o), 256'(MODE_DEC));
        chk("dec_cnt",  256'(blk_cnt_o), 256'(2));
        s_valid_i = 1'b1; s_data_i = rnd128();
        step(10);
        s_valid_i = 1'b0;
        chk("bp_data",   256'(m_data_o),  256'(FIPS_PT));
        chk("bp_ready",  256'(s_ready_o), 256'(0));
        chk("bp_starts", 256'(start_cnt), 256'(2));
        m_ready_i = 1'b1; step(); m_ready_i = 1'b0;
        chk("bp_release_ready", 256'(s_ready_o), 256'(1));
        chk("bp_release_valid", 256'(m_valid_o), 256'(0));

        // Timeout, late done pulse, error clear
        core_mute = 1'b1;
        send(rnd128(), MODE_ENC);
        wait_ph("tmo_wait", 0, n);
        core_mute = 1'b0;
        chk("tmo_cycles", 256'(n),         256'(TMO + 1));
        chk("tmo_err",    256'(err_o),     256'(2'b01));
        chk("tmo_cnt",    256'(blk_cnt_o), 256'(2));
        inject_valid = 1'b1; step(); inject_valid = 1'b0;
        step(2);
        chk("late_valid", 256'(m_valid_o), 256'(0));
        chk("late_cnt",   256'(blk_cnt_o), 256'(2));
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
        chk("err_clr", 256'(err_o), 256'(0));

        // Busy core delays the start; key load while running is rejected
        core_busy_i = 1'b1;
        s0 = start_cnt;
        send(rnd128(), MODE_DEC);
        step(5);
        chk("busy_no_start", 256'(start_cnt), 256'(s0));
        core_busy_i = 1'b0;
        step(2);
        chk("busy_started", 256'(start_cnt), 256'(s0 + 1));
        key_load_i = 1'b1; key_i = {rnd128(), rnd128()};
        step();
        key_load_i = 1'b0;
        chk("keyrej_err", 256'(err_o),  256'(2'b10));
        chk("keyrej_key", core_key_o,   FIPS_KEY);
        wait_ph("busy_wait", 3, n);
        m_ready_i = 1'b1; step(); m_ready_i = 1'b0;
        err_clr_i = 1'b1; step(); err_clr_i = 1'b0;

        // Reset mid-run
        send(rnd128(), MODE_ENC);
        step(5);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("mrst_key",   core_key_o,         256'(0));
        chk("mrst_cnt",   256'(blk_cnt_o),    256'(0));
        chk("mrst_valid", 256'(m_valid_o),    256'(0));
        chk("mrst_data",  256'(core_data_o),  256'(0));
        step(25);
        chk("mrst_stale", 256'(m_valid_o), 256'(0));
        key_load_i = 1'b1; key_i = FIPS_KEY;
        s_valid_i = 1'b1; s_data_i = FIPS_PT; s_mode_i = MODE_ENC;
        step();
        key_load_i = 1'b0; s_valid_i = 1'b0;
        wait_ph("mrst_wait", 3, n);
        chk("mrst_res", 256'(m_data_o),  256'(FIPS_CT));
        chk("mrst_cnt1", 256'(blk_cnt_o), 256'(1));
        m_ready_i = 1'b1; step(); m_ready_i = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            s_valid_i   = 1'($urandom_range(0, 1));
            s_data_i    = rnd128();
            s_mode_i    = 1'($urandom_range(0, 1));
            key_load_i  = ($urandom_range(0, 15) == 0);
            key_i       = {rnd128(), rnd128()};
            m_ready_i   = ($urandom_range(0, 3) != 0);
            core_busy_i = ($urandom_range(0, 3) == 0);
            err_clr_i   = ($urandom_range(0, 15) == 0);
            step();
        end
        s_valid_i = 1'b0; key_load_i = 1'b0; core_busy_i = 1'b0; err_clr_i = 1'b0;
        m_ready_i = 1'b1;
        step(100);
        chk("drain_idle", 256'(s_ready_o), 256'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
